uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Controller sequencing the UART_RX engine. Holds the RX configuration register and drives i_eight/i_pen/i_ohel/i_rate.
//  Watches o_rxrdy, issues the one-cycle read strobe and captures {ferr,perr,ovf,data} into a show-ahead FIFO.
//  Host logic drains that FIFO. Sits between UART_RX and the CPU/peripheral bus.
// PARAMETERS
//  CLK_HZ  100_000_000  system clock frequency; baud table rate = CLK_HZ/baud - 1 (integer divide)
//  AW      3            FIFO address width; depth = 2**AW entries of 11 bits
// PORTS
//  i_clk       in   1     system clock, rising edge
//  i_rst       in   1     asynchronous, active-high reset
//  i_cfg_we    in   1     config write strobe (one cycle)
//  i_cfg_din   in   7     {baud_sel[3:0], ohel, pen, eight}
//  o_cfg       out  7     current config register
//  o_eight     out  1     to UART_RX i_eight
//  o_pen       out  1     to UART_RX i_pen
//  o_ohel      out  1     to UART_RX i_ohel
//  o_rate      out  19    to UART_RX i_rate (baud table lookup of baud_sel)
//  i_rxrdy     in   1     from UART_RX o_rxrdy
//  i_perr      in   1     from UART_RX o_perr
//  i_ferr      in   1     from UART_RX o_ferr
//  i_ovf       in   1     from UART_RX o_ovf
//  i_rx_dout   in   8     from UART_RX o_rx_dout
//  o_read      out  1     to UART_RX i_read; registered one-cycle pulse
//  i_pop       in   1     host pops FIFO head
//  o_dout      out  11    FIFO head {ferr,perr,ovf,data[7:0]}; valid while !o_empty
//  o_empty     out  1     FIFO empty
//  o_full      out  1     FIFO full
//  o_count     out  AW+1  FIFO occupancy, 0..2**AW
//  o_drop      out  1     sticky: a received byte was lost to a full FIFO
//  o_err_cnt   out  8     saturating count of captured entries with any error flag
//  i_clr       in   1     clears o_drop and o_err_cnt
// BEHAVIOUR
//  Reset values:
//   - cfg = {4'd8,0,0,1}: 115200 baud, 8 data bits, no parity, ohel=0; o_rate = 867 at 100 MHz.
//   - o_read=0, o_empty=1, o_full=0, o_count=0, o_dout=0, o_drop=0, o_err_cnt=0, FSM=IDLE.
//  Baud table:
//   - sel 0..11 = 300,1200,2400,4800,9600,19200,38400,57600,115200,230400,460800,921600.
//   - sel 12..15 map to 115200. o_rate is registered and changes on the edge after cfg changes.
//  FSM, 3 states:
//   - IDLE: i_rxrdy=1 -> READ.
//   - READ: o_read=1 for exactly this cycle. Sample i_rx_dout and flags, push entry at the end of the cycle. -> WAIT.
//   - WAIT: hold until i_rxrdy=0, then -> IDLE. No second read strobe while rxrdy stays high.
//  Latency:
//   - i_rxrdy rises and is sampled at edge N; o_read is high during cycle N..N+1.
//   - Entry is written at edge N+1; o_empty falls after edge N+1.
//  Push while full: entry discarded, o_drop set, FIFO unchanged. A pop in the same cycle frees a slot, so push succeeds and count is unchanged.
//  Pop when empty: ignored. Push and pop in the same cycle when empty: push only; head visible the next cycle.
//  Pointers wrap modulo 2**AW. o_full = (o_count == 2**AW).
//  o_err_cnt increments once per accepted or dropped entry with any of ferr/perr/ovf set, and saturates at 255.
//  i_clr has priority over a same-cycle increment or drop.
//  i_cfg_we:
//   - Loads cfg, flushes the FIFO (count=0) and forces FSM to IDLE, even mid-READ/WAIT.
//   - An entry being pushed that cycle is discarded.
//   - o_drop and o_err_cnt are retained.
//  i_rst asserted mid-operation returns all state to reset values immediately (asynchronous).
// TESTING
//  1. Reset, then pulse i_rxrdy with dout=8'h5A and no flags -> exactly one o_read pulse; o_dout=11'h05A; o_count=1; i_pop -> o_empty=1.
//  2. cfg write 7'b0100_011 (sel 4, pen=1, eight=1) -> o_rate=10415, o_pen=1, o_eight=1 the next cycle; FIFO flushed.
//  3. Push 9 bytes 8'h00..8'h08 without popping (AW=3) -> o_full=1 after 8 pushes; o_drop=1; drain yields 00..07 in order.
//  4. Bytes with ferr, perr and ovf each set once -> o_dout MSBs 3'b100, 3'b010, 3'b001; o_err_cnt=3; i_clr -> 0.
//  5. FIFO full and push coincides with i_pop -> count stays 8, o_drop stays 0, new byte appears last in drain order.
//  6. i_cfg_we during WAIT, and i_rst asserted mid-READ -> FSM=IDLE, o_count=0; after rst, all outputs at reset values.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: bundles the config, UART_RX engine and host FIFO signals of uart_rx_ctrl
//   config : cfg_we, cfg_din -> cfg, eight, pen, ohel, rate
//   engine : rxrdy, perr, ferr, ovf, rx_dout -> read
//   host   : pop, clr -> dout, empty, full, count, drop, err_cnt
interface uart_rx_ctrl_if #(parameter int AW = 3);
  logic cfg_we;
  logic [6:0] cfg_din;
  logic [6:0] cfg;
  logic eight;
  logic pen;
  logic ohel;
  logic [18:0] rate;
  logic rxrdy;
  logic perr;
  logic ferr;
  logic ovf;
  logic [7:0] rx_dout;
  logic read;
  logic pop;
  logic [10:0] dout;
  logic empty;
  logic full;
  logic [AW:0] count;
  logic drop;
  logic [7:0] err_cnt;
  logic clr;
  modport master (
    output cfg_we, cfg_din, rxrdy, perr, ferr, ovf, rx_dout, pop, clr,
    input cfg, eight, pen, ohel, rate, read, dout, empty, full, count, drop, err_cnt
  );
  modport slave (
    input cfg_we, cfg_din, rxrdy, perr, ferr, ovf, rx_dout, pop, clr,
    output cfg, eight, pen, ohel, rate, read, dout, empty, full, count, drop, err_cnt
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences UART_RX reads into a show-ahead FIFO and holds the RX config
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uart_rx_ctrl_if.slave (config register, engine handshake, host FIFO port)
module uart_rx_ctrl #(
  parameter int CLK_HZ = 100_000_000,
  parameter int AW = 3
) (
  input logic clk,
  input logic rst,
  uart_rx_ctrl_if.slave bus
);
  localparam int DEPTH = 2**AW;
  localparam logic [18:0] RATE [16] = '{
    19'(CLK_HZ/300-1), 19'(CLK_HZ/1200-1), 19'(CLK_HZ/2400-1), 19'(CLK_HZ/4800-1),
    19'(CLK_HZ/9600-1), 19'(CLK_HZ/19200-1), 19'(CLK_HZ/38400-1), 19'(CLK_HZ/57600-1),
    19'(CLK_HZ/115200-1), 19'(CLK_HZ/230400-1), 19'(CLK_HZ/460800-1), 19'(CLK_HZ/921600-1),
    19'(CLK_HZ/115200-1), 19'(CLK_HZ/115200-1), 19'(CLK_HZ/115200-1), 19'(CLK_HZ/115200-1)
  };
  typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;
  state_t state, state_n;
  logic [6:0] cfg;
  logic [18:0] rate;
  logic read;
  logic [10:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic drop;
  logic [7:0] err_cnt;
  logic [10:0] entry;
  logic full, push, do_push, do_pop;
  assign entry = {bus.ferr, bus.perr, bus.ovf, bus.rx_dout};
  assign full = count == (AW+1)'(DEPTH);
  // a config write discards the entry being captured that cycle
  assign push = state == READ && !bus.cfg_we;
  assign do_pop = bus.pop && count != '0;
  // a same-cycle pop frees the slot a full FIFO needs
  assign do_push = push && (!full || do_pop);
  always_comb begin
    state_n = bus.cfg_we ? IDLE :
              state == IDLE ? (bus.rxrdy ? READ : IDLE) :
              state == READ ? WAIT :
              bus.rxrdy ? WAIT : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      read <= 1'b0;
      cfg <= 7'b1000_001;
      rate <= RATE[8];
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      drop <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      read <= state_n == READ;
      rate <= RATE[cfg[6:3]];
      if (bus.cfg_we) begin
        cfg <= bus.cfg_din;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(do_push);
        rd_ptr <= rd_ptr + AW'(do_pop);
        count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
      drop <= !bus.clr && (drop || (push && !do_push));
      err_cnt <= bus.clr ? '0 :
                 (push && |entry[10:8] && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= entry;
  end
  assign bus.cfg = cfg;
  assign bus.eight = cfg[0];
  assign bus.pen = cfg[1];
  assign bus.ohel = cfg[2];
  assign bus.rate = rate;
  assign bus.read = read;
  assign bus.dout = count == '0 ? '0 : mem[rd_ptr];
  assign bus.empty = count == '0;
  assign bus.full = full;
  assign bus.count = count;
  assign bus.drop = drop;
  assign bus.err_cnt = err_cnt;
endmodule
